sc_window_counter: RTL

- Downstream stage of the 16-input scaled unipolar gain-MAC.
- Consumes the MAC's 1-bit stochastic output stream and counts its ones over a fixed window of 2^WIN_LOG2 cycles, giving a binary result.
- Optionally skips a fixed number of leading cycles so the count aligns with operand load latency.
- Presents the result on a valid/ready handshake to the binary back-end, such as a requantiser or result buffer.

---
 rtl/sc_window_counter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sc_window_counter.sv
// Counts the ones in a 1-bit stochastic stream over a 2^WIN_LOG2-cycle window.
// An optional SKIP prefix is discarded first; the count is offered on a valid/ready port.
module sc_window_counter #(
  parameter int unsigned WIN_LOG2 = 8,
  parameter int unsigned SKIP     = 1,
  parameter int unsigned CNT_W    = WIN_LOG2 + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_bit,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_full
);

  localparam int unsigned SKIP_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SKIP = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic                HAS_SKIP  = (SKIP != 0);
  localparam logic [SKIP_W-1:0]   SKIP_LAST = SKIP_W'((SKIP == 0) ? 0 : SKIP - 1);
  localparam logic [WIN_LOG2-1:0] WIN_LAST  = '1;
  localparam logic [CNT_W-1:0]    FULL_CNT  = CNT_W'(2 ** WIN_LOG2);

  logic [1:0]          state_q,     state_d;
  logic [SKIP_W-1:0]   skip_cnt_q,  skip_cnt_d;
  logic [WIN_LOG2-1:0] win_cnt_q,   win_cnt_d;
  logic [CNT_W-1:0]    acc_q,       acc_d;
  logic [CNT_W-1:0]    out_cnt_q,   out_cnt_d;
  logic                out_full_q,  out_full_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q,      busy_d;
  logic [CNT_W-1:0]    sum_c;
  logic                launch_c;

  // Next-state and datapath; a launch from IDLE or from a DONE transfer shares one path.
  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    win_cnt_d   = win_cnt_q;
    acc_d       = acc_q;
    out_cnt_d   = out_cnt_q;
    out_full_d  = out_full_q;
    out_valid_d = out_valid_q;
    sum_c       = acc_q + CNT_W'(in_bit);
    launch_c    = 1'b0;

    case (state_q)
      S_IDLE: launch_c = start;
      S_SKIP: begin
        skip_cnt_d = skip_cnt_q + SKIP_W'(1);
        if (skip_cnt_q == SKIP_LAST) begin
          state_d   = S_ACC;
          win_cnt_d = '0;
        end
      end
      S_ACC: begin
        acc_d     = sum_c;
        win_cnt_d = win_cnt_q + WIN_LOG2'(1);
        if (win_cnt_q == WIN_LAST) begin
          out_cnt_d   = sum_c;
          out_full_d  = (sum_c == FULL_CNT);
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
          launch_c    = start;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch_c) begin
      acc_d = '0;
      if (HAS_SKIP) begin
        state_d    = S_SKIP;
        skip_cnt_d = '0;
      end else begin
        state_d   = S_ACC;
        win_cnt_d = '0;
      end
    end

    busy_d = (state_d == S_SKIP) || (state_d == S_ACC);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      skip_cnt_q  <= '0;
      win_cnt_q   <= '0;
      acc_q       <= '0;
      out_cnt_q   <= '0;
      out_full_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      win_cnt_q   <= win_cnt_d;
      acc_q       <= acc_d;
      out_cnt_q   <= out_cnt_d;
      out_full_q  <= out_full_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_cnt   = out_cnt_q;
  assign out_full  = out_full_q;

endmodule
